// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - state_e     : controller states (IDLE, RUN, DONE), 2-bit encoding
//   - cnt_width() : width of the bit counter for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter width is clog2(width). Legal widths start at 2, so the result
    // is always at least 1 bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell
//   Purely combinational one-bit full adder. It is the only arithmetic
//   element of the serial adder.
// Ports:
//   iA, iB    : operand bits
//   iC        : carry in
//   oSum      : iA ^ iB ^ iC
//   oCarryout : majority(iA, iB, iC)
module full_adder_cell (
    input  logic iA,
    input  logic iB,
    input  logic iC,
    output logic oSum,
    output logic oCarryout
);

    assign oSum      = iA ^ iB ^ iC;
    assign oCarryout = (iA & iB) | (iA & iC) | (iB & iC);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder. It uses a single full-adder cell and a carry flop. A
//   start handshake latches the operands and the carry-in. The block then
//   produces one sum bit per clock, LSB first. After WIDTH RUN cycles it
//   spends one DONE cycle, which gives one result every WIDTH+1 cycles.
//   {oCarryout, oSum} = iA + iB + iCin (unsigned, modulo 2^WIDTH).
// Parameters:
//   WIDTH     : operand/sum width, 2..64
// Ports:
//   iClk      : clock, rising edge
//   iRstn     : asynchronous active-low reset
//   iStart    : start request, accepted in IDLE or DONE
//   iA, iB    : operands, sampled on an accepted start
//   iCin      : carry-in, sampled on an accepted start
//   oBusy     : high during RUN
//   oDone     : one-cycle pulse when oSum/oCarryout are valid
//   oSum      : result, stable from oDone until the next accepted start
//   oCarryout : carry out of the MSB
//   oOvf      : signed overflow (only when SERIAL_ADDER_OVF_EN is defined)
// Configuration:
//   SERIAL_ADDER_OVF_EN : adds the oOvf output and its flop
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iCin,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oSum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             oOvf,
`endif
    output logic             oCarryout
);

    localparam int unsigned          CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               fa_sum;
    logic               fa_cout;

    full_adder_cell u_fa (
        .iA        (a_q[0]),
        .iB        (b_q[0]),
        .iC        (carry_q),
        .oSum      (fa_sum),
        .oCarryout (fa_cout)
    );

    // Next-state logic. A start is accepted in both IDLE and DONE. This lets
    // back-to-back additions run with no idle bubble. In RUN, carry_q holds
    // the carry into the bit being processed. On the last bit it is
    // therefore the carry into the MSB, which the overflow flag needs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    a_d     = iA;
                    b_d     = iB;
                    carry_d = iCin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                if (cnt_q == LAST) begin
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Reset aborts any addition in flight. The aborted
    // addition never signals done.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign oBusy     = (state_q == RUN);
    assign oDone     = (state_q == DONE);
    assign oSum      = sum_q;
    assign oCarryout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign oOvf      = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed, table-driven bench for serial_adder at WIDTH=8. It also runs
//   hand-written sequences for the following cases:
//   - a start request that arrives during RUN and must be ignored
//   - a reset asserted in the middle of an addition
//   - a back-to-back start issued in the DONE cycle
//   Checks of oOvf are compiled in only when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             iClk;
    logic             iRstn;
    logic             iStart;
    logic [WIDTH-1:0] iA;
    logic [WIDTH-1:0] iB;
    logic             iCin;
    logic             oBusy;
    logic             oDone;
    logic [WIDTH-1:0] oSum;
    logic             oCarryout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             oOvf;
`endif

    int nTests;
    int nFail;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] expSum;
        logic             expCout;
        logic             expOvf;
    } vec_t;

    vec_t vecs[11];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .iClk      (iClk),
        .iRstn     (iRstn),
        .iStart    (iStart),
        .iA        (iA),
        .iB        (iB),
        .iCin      (iCin),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oSum      (oSum),
`ifdef SERIAL_ADDER_OVF_EN
        .oOvf      (oOvf),
`endif
        .oCarryout (oCarryout)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // One comparison. It prints a FAIL line on a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advances to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Presents a start for exactly one edge. The task returns just after the
    // accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
        iStart = 1'b1;
        iA     = a;
        iB     = b;
        iCin   = cin;
        tick();
        iStart = 1'b0;
    endtask

    // Counts edges until oDone is seen. The wait is bounded. A timeout
    // returns -1, which fails the latency check of the caller.
    task automatic waitDone(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (oDone) begin
                cycles = i;
                break;
            end
        end
    endtask

    // Counts the oDone pulses seen over n cycles.
    task automatic countDone(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (oDone) pulses++;
        end
    endtask

    initial begin
        int cyc;
        int pulses;

        nTests = 0;
        nFail  = 0;

        // Expected values are hand-computed: {cout,sum} = a+b+cin.
        // ovf is set when two operands of the same sign give a result of the
        // other sign.
        vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[3]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[4]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0};
        vecs[10] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};

        iRstn  = 1'b0;
        iStart = 1'b0;
        iA     = '0;
        iB     = '0;
        iCin   = 1'b0;

        // Reset state
        repeat (3) tick();
        checkOutput("reset_busy", {63'd0, oBusy}, 64'd0);
        checkOutput("reset_done", {63'd0, oDone}, 64'd0);
        checkOutput("reset_sum", {56'd0, oSum}, 64'd0);
        checkOutput("reset_cout", {63'd0, oCarryout}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("reset_ovf", {63'd0, oOvf}, 64'd0);
`endif
        #2 iRstn = 1'b1;
        tick();

        // Table-driven vectors. oDone must first appear right after edge
        // k+WIDTH, where k is the accepting edge.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
            checkOutput($sformatf("v%0d_busy", i), {63'd0, oBusy}, 64'd1);
            waitDone(cyc);
            checkOutput($sformatf("v%0d_latency", i), 64'(cyc), 64'(WIDTH));
            checkOutput($sformatf("v%0d_sum", i), {56'd0, oSum}, {56'd0, vecs[i].expSum});
            checkOutput($sformatf("v%0d_cout", i), {63'd0, oCarryout}, {63'd0, vecs[i].expCout});
`ifdef SERIAL_ADDER_OVF_EN
            checkOutput($sformatf("v%0d_ovf", i), {63'd0, oOvf}, {63'd0, vecs[i].expOvf});
`endif
            tick();
            checkOutput($sformatf("v%0d_done_pulse", i), {63'd0, oDone}, 64'd0);
            checkOutput($sformatf("v%0d_sum_held", i), {56'd0, oSum}, {56'd0, vecs[i].expSum});
        end

        // A start pulse during RUN is ignored: one result of 0x30 and a
        // single oDone pulse.
        applyStimulus(8'h10, 8'h20, 1'b0);
        repeat (2) tick();
        iStart = 1'b1;
        iA     = 8'hAA;
        iB     = 8'hAA;
        tick();
        iStart = 1'b0;
        waitDone(cyc);
        checkOutput("ign_latency", 64'(cyc), 64'(WIDTH - 3));
        checkOutput("ign_sum", {56'd0, oSum}, 64'h30);
        countDone(20, pulses);
        checkOutput("ign_extra_done", 64'(pulses), 64'd0);
        checkOutput("ign_sum_held", {56'd0, oSum}, 64'h30);

        // Reset during RUN cycle 4 clears the outputs at once, and the
        // aborted addition never signals done.
        applyStimulus(8'h33, 8'h44, 1'b0);
        repeat (4) tick();
        iRstn = 1'b0;
        #1;
        checkOutput("abort_busy", {63'd0, oBusy}, 64'd0);
        checkOutput("abort_sum", {56'd0, oSum}, 64'd0);
        checkOutput("abort_cout", {63'd0, oCarryout}, 64'd0);
        checkOutput("abort_done", {63'd0, oDone}, 64'd0);
        #1 iRstn = 1'b1;
        countDone(20, pulses);
        checkOutput("abort_no_done", 64'(pulses), 64'd0);
        checkOutput("abort_idle", {63'd0, oBusy}, 64'd0);
        applyStimulus(8'h01, 8'h02, 1'b0);
        waitDone(cyc);
        checkOutput("abort_next_latency", 64'(cyc), 64'(WIDTH));
        checkOutput("abort_next_sum", {56'd0, oSum}, 64'h03);

        // Back-to-back: a start in the DONE cycle goes straight to RUN. The
        // next oDone arrives WIDTH+1 cycles after the previous one.
        tick();
        applyStimulus(8'h01, 8'h02, 1'b1);
        waitDone(cyc);
        checkOutput("b2b_first_sum", {56'd0, oSum}, 64'h04);
        iStart = 1'b1;
        iA     = 8'h0F;
        iB     = 8'h01;
        iCin   = 1'b0;
        tick();
        iStart = 1'b0;
        checkOutput("b2b_busy", {63'd0, oBusy}, 64'd1);
        waitDone(cyc);
        checkOutput("b2b_latency", 64'(cyc + 1), 64'(WIDTH + 1));
        checkOutput("b2b_sum", {56'd0, oSum}, 64'h10);
        checkOutput("b2b_cout", {63'd0, oCarryout}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
